// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus ID-stage read ports and the EX forwarding tap.
// The pipeline side drives through master; the register file uses slave.
interface wb_regfile_if #(
    parameter int NREGS = 32,
    parameter int DW    = 32
);
    localparam int AW = $clog2(NREGS);

    logic [1:0]    wb_in_RegSrc;
    logic          wb_in_RegWrite;
    logic [DW-1:0] wb_in_ALUOut_EXEC;
    logic [DW-1:0] wb_in_Mem_dataOut;
    logic [15:0]   wb_in_immediate;
    logic          wb_in_load_signal;
    logic [AW-1:0] wb_in_write_reg_dest;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] wb_fwd_data;
    logic [AW-1:0] wb_fwd_dest;
    logic          wb_fwd_valid;
    logic [31:0]   retire_count;

    modport master (
        output wb_in_RegSrc, wb_in_RegWrite, wb_in_ALUOut_EXEC, wb_in_Mem_dataOut,
        output wb_in_immediate, wb_in_load_signal, wb_in_write_reg_dest,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_fwd_data, wb_fwd_dest, wb_fwd_valid, retire_count
    );

    modport slave (
        input  wb_in_RegSrc, wb_in_RegWrite, wb_in_ALUOut_EXEC, wb_in_Mem_dataOut,
        input  wb_in_immediate, wb_in_load_signal, wb_in_write_reg_dest,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_fwd_data, wb_fwd_dest, wb_fwd_valid, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back value select, 32-entry architectural register file with write-through
// read bypass, EX forwarding tap and retired-write counter.
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [DW-1:0] r_regs [NREGS];
    logic [31:0]   r_retire_count;
    logic [DW-1:0] w_wb_data;
    logic          w_wb_valid;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    function automatic logic [DW-1:0] sext_byte(input logic [7:0] b);
        return {{(DW-8){b[7]}}, b};
    endfunction

    function automatic logic [DW-1:0] sext_half(input logic [15:0] h);
        return {{(DW-16){h[15]}}, h};
    endfunction

    // Write-back source select
    always_comb begin
        w_wb_data = {DW{1'b0}};
        case (bus.wb_in_RegSrc)
            2'b00: w_wb_data = bus.wb_in_ALUOut_EXEC;
            2'b01: begin
                if (bus.wb_in_load_signal) begin
                    w_wb_data = sext_byte(bus.wb_in_Mem_dataOut[7:0]);
                end else begin
                    w_wb_data = bus.wb_in_Mem_dataOut;
                end
            end
            2'b10: w_wb_data = {bus.wb_in_immediate, 16'h0000};
            2'b11: w_wb_data = sext_half(bus.wb_in_immediate);
            default: w_wb_data = {DW{1'b0}};
        endcase
    end

    // Writes to r0 never count as commits, so they are filtered out of the valid tap
    always_comb begin
        w_wb_valid = bus.wb_in_RegWrite && (bus.wb_in_write_reg_dest != {AW{1'b0}});
    end

    // Read port a: r0 constant, then same-cycle bypass, then stored value
    always_comb begin
        w_rd_a = {DW{1'b0}};
        if (bus.rd_addr_a == {AW{1'b0}}) begin
            w_rd_a = {DW{1'b0}};
        end else if (w_wb_valid && (bus.rd_addr_a == bus.wb_in_write_reg_dest)) begin
            w_rd_a = w_wb_data;
        end else begin
            w_rd_a = r_regs[bus.rd_addr_a];
        end
    end

    // Read port b: identical priority to port a
    always_comb begin
        w_rd_b = {DW{1'b0}};
        if (bus.rd_addr_b == {AW{1'b0}}) begin
            w_rd_b = {DW{1'b0}};
        end else if (w_wb_valid && (bus.rd_addr_b == bus.wb_in_write_reg_dest)) begin
            w_rd_b = w_wb_data;
        end else begin
            w_rd_b = r_regs[bus.rd_addr_b];
        end
    end

    // Register file commit; reset clears every entry immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {DW{1'b0}};
            end
        end else if (w_wb_valid) begin
            r_regs[bus.wb_in_write_reg_dest] <= w_wb_data;
        end
    end

    // Retired-write counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= 32'd0;
        end else if (w_wb_valid) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign bus.rd_data_a    = w_rd_a;
    assign bus.rd_data_b    = w_rd_b;
    assign bus.wb_fwd_data  = w_wb_data;
    assign bus.wb_fwd_dest  = bus.wb_in_write_reg_dest;
    assign bus.wb_fwd_valid = w_wb_valid;
    assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile with hand-computed expected values.
module tb_wb_regfile;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    wb_regfile_if #(.NREGS(32), .DW(32)) bus ();

    wb_regfile #(.NREGS(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic ld,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [15:0] imm, input logic [4:0] dest);
        bus.wb_in_RegWrite       = we;
        bus.wb_in_RegSrc         = src;
        bus.wb_in_load_signal    = ld;
        bus.wb_in_ALUOut_EXEC    = alu;
        bus.wb_in_Mem_dataOut    = mem;
        bus.wb_in_immediate      = imm;
        bus.wb_in_write_reg_dest = dest;
    endtask

    task automatic idle();
        bus.wb_in_RegWrite = 1'b0;
    endtask

    // Commit one value, then read it back through port a with the write removed
    task automatic wr_and_read(input string tag, input logic [1:0] src, input logic ld,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [15:0] imm, input logic [4:0] dest,
                               input logic [31:0] exp);
        drive(1'b1, src, ld, alu, mem, imm, dest);
        #1;
        chk({tag, "_fwd"}, bus.wb_fwd_data, exp);
        step();
        idle();
        bus.rd_addr_a = dest;
        #1;
        chk({tag, "_reg"}, bus.rd_data_a, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd0;
        drive(1'b1, 2'b00, 1'b0, 32'h0000_1234, 32'h0, 16'h0, 5'd5);
        #1;
        chk("rst_count", bus.retire_count, 32'd0);
        chk("rst_fwd_valid", {31'd0, bus.wb_fwd_valid}, 32'd1);
        chk("rst_fwd_data", bus.wb_fwd_data, 32'h0000_1234);
        step();
        chk("rst_edge_count", bus.retire_count, 32'd0);
        idle();
        bus.rd_addr_a = 5'd5;
        #1;
        chk("rst_r5", bus.rd_data_a, 32'd0);

        // Release between edges with the write held; first edge after release commits
        bus.wb_in_RegWrite = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_count", bus.retire_count, 32'd0);
        step();
        chk("first_commit_count", bus.retire_count, 32'd1);
        idle();
        #1;
        chk("first_commit_r5", bus.rd_data_a, 32'h0000_1234);

        wr_and_read("src_alu",  2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0, 16'h0, 5'd3, 32'hDEAD_BEEF);
        wr_and_read("src_lui",  2'b10, 1'b0, 32'h0, 32'h0, 16'hABCD, 5'd4, 32'hABCD_0000);
        wr_and_read("src_sext", 2'b11, 1'b0, 32'h0, 32'h0, 16'h8001, 5'd6, 32'hFFFF_8001);
        wr_and_read("src_lb",   2'b01, 1'b1, 32'h0, 32'h0000_00F0, 16'h0, 5'd8, 32'hFFFF_FFF0);
        wr_and_read("src_lw",   2'b01, 1'b0, 32'h0, 32'h1234_5678, 16'h0, 5'd9, 32'h1234_5678);
        wr_and_read("src_lbpos", 2'b01, 1'b1, 32'h0, 32'hFFFF_FF7F, 16'h0, 5'd12, 32'h0000_007F);
        wr_and_read("src_sextpos", 2'b11, 1'b0, 32'h0, 32'h0, 16'h7FFF, 5'd13, 32'h0000_7FFF);
        chk("count_after_mux", bus.retire_count, 32'd8);

        // Bypass: r7 old value first, then same-cycle write-through
        bus.rd_addr_b = 5'd7;
        #1;
        chk("byp_old_b", bus.rd_data_b, 32'd0);
        step();
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 16'h0, 5'd7);
        bus.rd_addr_a = 5'd7;
        #1;
        chk("byp_a", bus.rd_data_a, 32'h0000_0055);
        chk("byp_b", bus.rd_data_b, 32'h0000_0055);
        chk("byp_fwd_dest", {27'd0, bus.wb_fwd_dest}, 32'd7);
        step();
        idle();
        #1;
        chk("byp_after_a", bus.rd_data_a, 32'h0000_0055);
        chk("byp_count", bus.retire_count, 32'd9);

        // Register 0 write is discarded
        drive(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 16'h0, 5'd0);
        bus.rd_addr_a = 5'd0;
        #1;
        chk("r0_pre", bus.rd_data_a, 32'd0);
        chk("r0_valid", {31'd0, bus.wb_fwd_valid}, 32'd0);
        step();
        idle();
        #1;
        chk("r0_post", bus.rd_data_a, 32'd0);
        chk("r0_count", bus.retire_count, 32'd9);

        // Back-to-back to the same register: last wins, both count
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 16'h0, 5'd10);
        step();
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 16'h0, 5'd10);
        step();
        idle();
        bus.rd_addr_a = 5'd10;
        #1;
        chk("b2b_r10", bus.rd_data_a, 32'h0000_0002);
        chk("b2b_count", bus.retire_count, 32'd11);

        // Unknown inputs with RegWrite low
        bus.wb_in_RegSrc         = 2'bxx;
        bus.wb_in_ALUOut_EXEC    = 32'hxxxx_xxxx;
        bus.wb_in_write_reg_dest = 5'bxxxxx;
        step();
        step();
        chk("x_count", bus.retire_count, 32'd11);
        chk("x_r10", bus.rd_data_a, 32'h0000_0002);

        // Counter wrap
        force dut.r_retire_count = 32'hFFFF_FFFE;
        step();
        step();
        release dut.r_retire_count;
        #1;
        chk("wrap_preload", bus.retire_count, 32'hFFFF_FFFE);
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0AAA, 32'h0, 16'h0, 5'd11);
        step();
        chk("wrap_ffffffff", bus.retire_count, 32'hFFFF_FFFF);
        step();
        chk("wrap_zero", bus.retire_count, 32'd0);
        step();
        chk("wrap_one", bus.retire_count, 32'd1);

        // Fill r1..r31, then asynchronous reset between edges
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 2'b00, 1'b0, 32'hA000_0000 | 32'(i), 32'h0, 16'h0, 5'(i));
            step();
        end
        idle();
        bus.rd_addr_a = 5'd31;
        bus.rd_addr_b = 5'd1;
        #1;
        chk("fill_r31", bus.rd_data_a, 32'hA000_001F);
        chk("fill_r1", bus.rd_data_b, 32'hA000_0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_r31", bus.rd_data_a, 32'd0);
        chk("arst_r1", bus.rd_data_b, 32'd0);
        chk("arst_count", bus.retire_count, 32'd0);
        for (int i = 2; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(33 - i);
            #1;
            chk("arst_all_a", bus.rd_data_a, 32'd0);
            chk("arst_all_b", bus.rd_data_b, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file: consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32 x 32-bit register file on the rising clock edge. Provides two combinational read ports with same-cycle write-through bypass to the ID stage, a forwarding tap for the EX-stage forwarding unit, and a retired-write counter for debug and performance monitoring.

## Interface
- NREGS, 32, number of architectural registers; register 0 is hard-wired to zero.
- DW, 32, data width.
- clk  in  1  pipeline clock; all state updates occur on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_in_RegSrc  in  2  write-back source select: 00 = ALU, 01 = memory, 10 = {imm, 16'h0} (LUI), 11 = sign-extended imm.
- wb_in_RegWrite  in  1  write enable from MEM/WB.
- wb_in_ALUOut_EXEC  in  32  ALU result.
- wb_in_Mem_dataOut  in  32  data-memory read word.
- wb_in_immediate  in  16  instruction immediate.
- wb_in_load_signal  in  1  byte-load qualifier, used only when RegSrc = 01.
- wb_in_write_reg_dest  in  5  destination register.
- rd_addr_a, rd_addr_b  in  5 each  ID-stage read addresses.
- rd_data_a, rd_data_b  out  32 each  read data (combinational).
- wb_fwd_data  out  32  selected write-back value (combinational).
- wb_fwd_dest  out  5  destination register of the write in flight.
- wb_fwd_valid  out  1  RegWrite & (dest != 0).
- retire_count  out  32  number of committed register writes.

## Operation
- Write-back value selection (combinational):
  - 00: ALUOut.
  - 01 with load_signal = 0: Mem_dataOut.
  - 01 with load_signal = 1: {{24{Mem_dataOut[7]}}, Mem_dataOut[7:0]}.
  - 10: {immediate, 16'h0000}.
  - 11: {{16{immediate[15]}}, immediate}.
- Commit:
  - At the rising edge, when wb_fwd_valid = 1, regs[dest] <= wb_fwd_data.
  - Writes to register 0 are discarded. Register 0 always reads 0 and never increments retire_count.
- Read port x:
  - addr = 0 gives 0.
  - Otherwise, if wb_fwd_valid and addr == dest, gives wb_fwd_data (write-through bypass).
  - Otherwise gives regs[addr].
  - Ports a and b are independent and may read the same address.
- retire_count increments by 1 on each committed write and wraps from 0xFFFFFFFF to 0.
- Reset: asserting rst_n low immediately clears all registers and retire_count to 0, including mid-cycle, and overrides any write in that cycle. The first commit happens at the first rising edge after rst_n is released.
- X inputs with RegWrite = 0 must not corrupt state.

## Timing
- Write latency: the value is architecturally visible in regs one rising edge after presentation. Through the bypass it is visible in the same cycle.
- Read latency: 0 cycles (combinational from address and write-back inputs).
- Forwarding tap: 0-cycle latency, held as long as the inputs are held.
- Reset values: every register = 0, retire_count = 0, rd_data_* = 0 whenever no bypass applies, wb_fwd_* follow the inputs.
- Back-to-back writes to the same register on consecutive edges: the last one wins, and each one counts.
- No stalls or handshakes. Every rising edge with wb_fwd_valid = 1 commits.

## Test plan
- Reset: hold rst_n = 0 with RegWrite = 1, dest = 5, ALU = 0x1234, then release. Required: rd_data(5) = 0 and retire_count = 0 until the first edge after release.
- Source mux:
  - RegSrc = 00, ALU = 0xDEADBEEF to r3; read r3 after the edge gives 0xDEADBEEF.
  - RegSrc = 10, imm = 0xABCD gives 0xABCD0000.
  - RegSrc = 11, imm = 0x8001 gives 0xFFFF8001.
  - RegSrc = 01, load_signal = 1, Mem = 0x000000F0 gives 0xFFFFFFF0.
- Bypass: in the same cycle, write r7 = 0x55 and set rd_addr_a = 7. Required: rd_data_a = 0x55 before the edge, while rd_data_b on r7 read one cycle earlier returned the old value.
- Register 0: RegWrite = 1, dest = 0, ALU = 0xFFFFFFFF. Required: rd_data(0) = 0 both before and after the edge, wb_fwd_valid = 0, and retire_count unchanged.
- Counter wrap: preload retire_count to 0xFFFFFFFE via two-cycle force, then perform 3 valid writes. Required: 0xFFFFFFFF, then 0, then 1.
- Async reset mid-run: fill r1–r31, then pulse rst_n low between edges. Required: all reads return 0 immediately, without waiting for a clock edge.
